// File: rtl/riscv_trace_pkg.sv
// Purpose: shared types and constants for the retirement tracker (record layout, instr-type one-hots, field positions).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_trace_pkg;

   localparam int XLEN_P  = 32;
   localparam int SEQ_W_P = 16;
   localparam int TYPE_W  = 6;
   localparam int REG_W   = 5;

   // One-hot instruction type, bit order {j,u,b,s,i,r}
   localparam logic [TYPE_W-1:0] T_R = 6'b000001;
   localparam logic [TYPE_W-1:0] T_I = 6'b000010;
   localparam logic [TYPE_W-1:0] T_S = 6'b000100;
   localparam logic [TYPE_W-1:0] T_B = 6'b001000;
   localparam logic [TYPE_W-1:0] T_U = 6'b010000;
   localparam logic [TYPE_W-1:0] T_J = 6'b100000;

   // Register-field LSB positions within the instruction word
   localparam int RD_LSB  = 7;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;

   typedef struct packed {
      logic [SEQ_W_P-1:0] seq;
      logic [XLEN_P-1:0]  pc;
      logic [XLEN_P-1:0]  instr;
      logic [TYPE_W-1:0]  itype;
      logic [REG_W-1:0]   rd;
      logic [XLEN_P-1:0]  rd_val;
   } retire_rec_t;

   function automatic logic is_onehot6(input logic [TYPE_W-1:0] t);
      return (t != '0) && ((t & (t - 6'd1)) == '0);
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Purpose: synchronous record FIFO with valid/ready output and full/empty flags.
// Latency: push to out_valid_o is 1 cycle; head data is read combinationally from storage.
// Backpressure: push while full is accepted only if the head pops the same cycle; otherwise ignored.
module trace_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] push_dat_i,
   output logic         full_o,
   output logic         empty_o,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_dat_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q;
   logic          pop, wr_en;

   assign empty_o     = (cnt_q == '0);
   assign full_o      = (cnt_q == (AW+1)'(DEPTH));
   assign out_valid_o = ~empty_o;
   assign pop         = out_valid_o & out_ready_i;
   assign wr_en       = push_i & (~full_o | pop);
   assign out_dat_o   = empty_o ? '0 : mem_q[rd_ptr_q];

   // Pointer and occupancy bookkeeping; DEPTH is a power of 2 so pointers wrap naturally
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
      end
   end

   // Storage write; contents need no reset because empty masks the head
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/retire_trace.sv
// Purpose: shadows fetched instrs through ISS/EX/MEM/WB and emits one retirement record per instr into a FIFO.
// Latency: fetch capture to FIFO push 4 cycles (no stall/flush); push to out_valid 1 cycle.
// Backpressure: out_valid/out_ready; records arriving at a full FIFO with no pop are dropped and counted.
// Optional: RETIRE_TRACE_CHECK_EN enables the sticky err_mismatch retire-strobe / type checker.
module retire_trace
   import riscv_trace_pkg::*;
#(
   parameter int XLEN       = XLEN_P,
   parameter int FIFO_DEPTH = 8,
   parameter int SEQ_W      = SEQ_W_P
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           fetch_valid,
   input  logic [XLEN-1:0]                fetch_pc,
   input  logic [XLEN-1:0]                fetch_instr,
   input  logic [5:0]                     iss_type,
   input  logic                           stall,
   input  logic                           flush,
   input  logic [XLEN-1:0]                wb_rd_val,
   input  logic                           instr_retired,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [$bits(retire_rec_t)-1:0] out_rec,
   output logic [15:0]                    overflow_cnt,
   output logic                           err_mismatch
);
   logic            iss_vld_q, ex_vld_q, mem_vld_q, wb_vld_q;
   logic [XLEN-1:0] iss_pc_q, ex_pc_q, mem_pc_q, wb_pc_q;
   logic [XLEN-1:0] iss_instr_q, ex_instr_q, mem_instr_q, wb_instr_q;
   logic [5:0]      ex_type_q, mem_type_q, wb_type_q;

   logic [SEQ_W-1:0] seq_q;
   logic [15:0]      ovf_q;
   retire_rec_t      push_rec;
   logic [4:0]       rd_dec;
   logic             fifo_full, drop, unused_fifo_empty;

   // Shadow slot advance: flush beats stall; MEM and WB always advance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iss_vld_q <= 1'b0; ex_vld_q <= 1'b0; mem_vld_q <= 1'b0; wb_vld_q <= 1'b0;
         iss_pc_q <= '0; ex_pc_q <= '0; mem_pc_q <= '0; wb_pc_q <= '0;
         iss_instr_q <= '0; ex_instr_q <= '0; mem_instr_q <= '0; wb_instr_q <= '0;
         ex_type_q <= '0; mem_type_q <= '0; wb_type_q <= '0;
      end else begin
         wb_vld_q    <= mem_vld_q;
         wb_pc_q     <= mem_pc_q;
         wb_instr_q  <= mem_instr_q;
         wb_type_q   <= mem_type_q;
         mem_vld_q   <= ex_vld_q;
         mem_pc_q    <= ex_pc_q;
         mem_instr_q <= ex_instr_q;
         mem_type_q  <= ex_type_q;
         if (stall || flush) begin
            ex_vld_q <= 1'b0;
         end else begin
            ex_vld_q   <= iss_vld_q;
            ex_pc_q    <= iss_pc_q;
            ex_instr_q <= iss_instr_q;
            ex_type_q  <= iss_type;
         end
         if (flush) begin
            iss_vld_q <= 1'b0;
         end else if (!stall) begin
            iss_vld_q   <= fetch_valid;
            iss_pc_q    <= fetch_pc;
            iss_instr_q <= fetch_instr;
         end
      end
   end

   // Record build from the WB slot; stores and branches have no destination register
   always_comb begin
      rd_dec = wb_instr_q[RD_LSB +: 5];
      if ((wb_type_q & (T_S | T_B)) != 6'd0) rd_dec = 5'd0;
      push_rec        = '0;
      push_rec.seq    = seq_q;
      push_rec.pc     = wb_pc_q;
      push_rec.instr  = wb_instr_q;
      push_rec.itype  = wb_type_q;
      push_rec.rd     = rd_dec;
      push_rec.rd_val = (rd_dec != 5'd0) ? wb_rd_val : '0;
   end

   // When full, out_valid is high, so a pop happens exactly when out_ready is high
   assign drop = wb_vld_q & fifo_full & ~out_ready;

   // Sequence number counts every push attempt; overflow counter saturates
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seq_q <= '0;
         ovf_q <= '0;
      end else begin
         if (wb_vld_q) seq_q <= seq_q + 1'b1;
         if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
      end
   end

   assign overflow_cnt = ovf_q;

   trace_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     ($bits(retire_rec_t))
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (wb_vld_q),
      .push_dat_i  (push_rec),
      .full_o      (fifo_full),
      .empty_o     (unused_fifo_empty),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_dat_o   (out_rec)
   );

`ifdef RETIRE_TRACE_CHECK_EN
   logic err_q;

   // Sticky error: core retire strobe disagrees with WB shadow, or WB type is not one-hot
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if ((instr_retired != wb_vld_q) || (wb_vld_q && !is_onehot6(wb_type_q))) begin
         err_q <= 1'b1;
      end
   end

   assign err_mismatch = err_q;
`else
   logic unused_instr_retired;
   assign unused_instr_retired = instr_retired;
   assign err_mismatch         = 1'b0;
`endif

endmodule

// File: tb/tb_retire_trace.sv
// Purpose: directed self-checking bench for retire_trace (latency, stall, flush, overflow, reset, checker).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: out_ready driven directly by the stimulus sequence.
module tb_retire_trace;
   import riscv_trace_pkg::*;

   localparam int REC_W = $bits(retire_rec_t);

   localparam logic [31:0] I0   = 32'h0050_0293; // addi x5,x0,5
   localparam logic [31:0] I1   = 32'h0010_0313; // addi x6,x0,1
   localparam logic [31:0] I2   = 32'h0020_0393; // addi x7,x0,2
   localparam logic [31:0] I3   = 32'h0000_0013; // nop, rd=x0
   localparam logic [31:0] IBEQ = 32'h0020_8463; // beq x1,x2,+8 (bits 11:7 = 8)
   localparam logic [31:0] RDV  = 32'h1234_5678;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             fetch_valid = 1'b0;
   logic [31:0]      fetch_pc = '0;
   logic [31:0]      fetch_instr = '0;
   logic [5:0]       iss_type = T_I;
   logic             stall = 1'b0;
   logic             flush = 1'b0;
   logic [31:0]      wb_rd_val = RDV;
   logic             instr_retired;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [REC_W-1:0] out_rec;
   logic [15:0]      overflow_cnt;
   logic             err_mismatch;

   retire_rec_t rec_v;
   assign rec_v = retire_rec_t'(out_rec);

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   logic exp_err;

   retire_rec_t got[$];

   retire_trace dut (
      .clk           (clk),
      .reset         (reset),
      .fetch_valid   (fetch_valid),
      .fetch_pc      (fetch_pc),
      .fetch_instr   (fetch_instr),
      .iss_type      (iss_type),
      .stall         (stall),
      .flush         (flush),
      .wb_rd_val     (wb_rd_val),
      .instr_retired (instr_retired),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_rec       (out_rec),
      .overflow_cnt  (overflow_cnt),
      .err_mismatch  (err_mismatch)
   );

   always #5 clk = ~clk;

   // Reference model of the core's own slot valids, used to drive a truthful retire strobe
   logic m_iss, m_ex, m_mem, m_wb;
   logic force_bad = 1'b0;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_iss <= 1'b0; m_ex <= 1'b0; m_mem <= 1'b0; m_wb <= 1'b0;
      end else begin
         m_wb  <= m_mem;
         m_mem <= m_ex;
         m_ex  <= (stall | flush) ? 1'b0 : m_iss;
         m_iss <= flush ? 1'b0 : (stall ? m_iss : fetch_valid);
      end
   end
   assign instr_retired = m_wb & ~force_bad;

   // Consumer side: capture every accepted record
   always @(posedge clk) begin
      if (!reset && out_valid && out_ready) got.push_back(rec_v);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] pc, input logic [31:0] instr);
      fetch_valid = 1'b1;
      fetch_pc    = pc;
      fetch_instr = instr;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic retire_rec_t getrec(input int i);
      if (i < got.size()) return got[i];
      return '0;
   endfunction

   initial begin
`ifdef RETIRE_TRACE_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      // Reset state
      repeat (2) tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_rec", out_rec, 0);
      chk("rst_overflow", overflow_cnt, 0);
      chk("rst_err", err_mismatch, 0);
      reset = 1'b0;
      tick();

      // 1: four straight instructions, latency and contents
      got.delete();
      present(32'h2000, I0); tick();
      present(32'h2004, I1); tick();
      present(32'h2008, I2); tick();
      present(32'h200C, I3); tick();
      chk("t1_not_yet_valid", out_valid, 0);
      fetch_valid = 1'b0; tick();
      chk("t1_first_valid", out_valid, 1);
      chk("t1_head_pc", rec_v.pc, 32'h2000);
      chk("t1_head_seq", rec_v.seq, 0);
      repeat (6) tick();
      chk("t1_count", got.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("t1_seq", getrec(i).seq, i);
         chk("t1_pc", getrec(i).pc, 32'h2000 + 4*i);
      end
      chk("t1_rd0", getrec(0).rd, 5);
      chk("t1_rdval0", getrec(0).rd_val, RDV);
      chk("t1_instr1", getrec(1).instr, I1);
      chk("t1_rd3_x0", getrec(3).rd, 0);
      chk("t1_rdval3_x0", getrec(3).rd_val, 0);
      chk("t1_type", getrec(2).itype, T_I);

      // 2: two-cycle stall with 0x2004 held in ISS
      got.delete();
      present(32'h2000, I0); tick();
      present(32'h2004, I1); tick();
      stall = 1'b1;
      present(32'h2008, I2); tick(); tick();
      stall = 1'b0; tick();
      present(32'h200C, I3); tick();
      fetch_valid = 1'b0;
      repeat (8) tick();
      chk("t2_count", got.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("t2_seq", getrec(i).seq, 4 + i);
         chk("t2_pc", getrec(i).pc, 32'h2000 + 4*i);
      end

      // 3: taken branch at 0x2004 flushes 0x2008 (ISS) and 0x200C (fetch)
      got.delete();
      present(32'h2000, I0); tick();
      present(32'h2004, IBEQ); tick();
      iss_type = T_B;
      present(32'h2008, I2); tick();
      iss_type = T_I;
      flush = 1'b1;
      present(32'h200C, I3); tick();
      flush = 1'b0;
      present(32'h3000, I1); tick();
      fetch_valid = 1'b0;
      repeat (8) tick();
      chk("t3_count", got.size(), 3);
      chk("t3_pc0", getrec(0).pc, 32'h2000);
      chk("t3_pc1", getrec(1).pc, 32'h2004);
      chk("t3_pc2", getrec(2).pc, 32'h3000);
      chk("t3_seq2", getrec(2).seq, 10);
      chk("t3_br_type", getrec(1).itype, T_B);
      chk("t3_br_rd", getrec(1).rd, 0);
      chk("t3_br_rdval", getrec(1).rd_val, 0);

      // 4: consumer stalled, 10 records into an 8-deep FIFO
      reset = 1'b1; tick();
      reset = 1'b0; tick();
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         present(32'h4000 + 4*i, I0); tick();
      end
      fetch_valid = 1'b0; tick();
      chk("t4_valid_held", out_valid, 1);
      chk("t4_head_seq_mid", rec_v.seq, 0);
      repeat (4) tick();
      chk("t4_head_seq_end", rec_v.seq, 0);
      chk("t4_head_pc", rec_v.pc, 32'h4000);
      chk("t4_overflow", overflow_cnt, 2);
      got.delete();
      out_ready = 1'b1;
      repeat (10) tick();
      chk("t4_drain_count", got.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk("t4_drain_seq", getrec(i).seq, i);
         chk("t4_drain_pc", getrec(i).pc, 32'h4000 + 4*i);
      end
      chk("t4_empty", out_valid, 0);

      // 5: reset with 3 records queued
      out_ready = 1'b0;
      present(32'h5000, I0); tick();
      present(32'h5004, I1); tick();
      present(32'h5008, I2); tick();
      fetch_valid = 1'b0;
      repeat (5) tick();
      chk("t5_queued_valid", out_valid, 1);
      chk("t5_queued_seq", rec_v.seq, 10);
      chk("t5_ovf_before", overflow_cnt, 2);
      reset = 1'b1;
      #1;
      chk("t5_rst_valid", out_valid, 0);
      chk("t5_rst_ovf", overflow_cnt, 0);
      chk("t5_rst_rec", out_rec, 0);
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      got.delete();
      present(32'h6000, I0); tick();
      fetch_valid = 1'b0;
      repeat (7) tick();
      chk("t5_count", got.size(), 1);
      chk("t5_seq", getrec(0).seq, 0);
      chk("t5_pc", getrec(0).pc, 32'h6000);

      // 6: retire strobe withheld while WB holds a valid instr
      chk("t6_err_before", err_mismatch, 0);
      present(32'h7000, I0); tick();
      fetch_valid = 1'b0;
      repeat (3) tick();
      force_bad = 1'b1; tick();
      force_bad = 1'b0;
      chk("t6_err_set", err_mismatch, exp_err);
      repeat (3) tick();
      chk("t6_err_held", err_mismatch, exp_err);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
